// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps and traps on unsupported instructions.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [3:0] State,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [3:0] AluAdd = 4'd0, AluAddu = 4'd1, AluSub = 4'd2, AluSubu = 4'd3,
                         AluSllv = 4'd4, AluSrlv = 4'd5, AluSrav = 4'd6, AluAnd = 4'd7,
                         AluOr = 4'd8, AluXor = 4'd9, AluNor = 4'd10, AluSlt = 4'd11,
                         AluSltu = 4'd12, AluSll = 4'd13, AluSrl = 4'd14, AluSra = 4'd15;

  state_e     state_q, state_d;
  logic [3:0] r_alu_op;
  logic       funct_ok;
  logic [3:0] i_alu_op;

  // Funct and Op are held stable by the datapath, so the ALU code is decoded live.
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = AluAdd;
    case (Funct)
      6'h20:   r_alu_op = AluAdd;
      6'h21:   r_alu_op = AluAddu;
      6'h22:   r_alu_op = AluSub;
      6'h23:   r_alu_op = AluSubu;
      6'h24:   r_alu_op = AluAnd;
      6'h25:   r_alu_op = AluOr;
      6'h26:   r_alu_op = AluXor;
      6'h27:   r_alu_op = AluNor;
      6'h2A:   r_alu_op = AluSlt;
      6'h2B:   r_alu_op = AluSltu;
      6'h00:   r_alu_op = AluSll;
      6'h02:   r_alu_op = AluSrl;
      6'h03:   r_alu_op = AluSra;
      6'h04:   r_alu_op = AluSllv;
      6'h06:   r_alu_op = AluSrlv;
      6'h07:   r_alu_op = AluSrav;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_alu_op = AluAdd;
    case (Op)
      6'h09:   i_alu_op = AluAddu;
      6'h0C:   i_alu_op = AluAnd;
      6'h0D:   i_alu_op = AluOr;
      default: i_alu_op = AluAdd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (Op)
          6'h23, 6'h2B:               state_d = StMemAdr;
          6'h00:                      state_d = funct_ok ? StRExec : StTrap;
          6'h04, 6'h05:               state_d = StBranch;
          6'h08, 6'h09, 6'h0C, 6'h0D: state_d = StIExec;
          6'h02:                      state_d = StJump;
          default:                    state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (Op == 6'h23) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StRExec:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    PCSource = 2'd0;
    ALUOp    = AluAdd;
    Illegal  = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'd1;
      end
      StDecode: ALUSrcB = 2'd3;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_alu_op;
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUOp    = r_alu_op;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = AluSub;
        PCSource = 2'd1;
        PCWrite  = (Op == 6'h05) ? ~Zero : Zero;
      end
      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp   = i_alu_op;
      end
      StIWb: begin
        RegWrite = 1'b1;
        ALUOp    = i_alu_op;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      StTrap:  Illegal = 1'b1;
      default: Illegal = 1'b1;
    endcase
    // Reset suppresses every architectural write regardless of state.
    if (rst) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its
// state sequence and checks decoded control outputs against hand-derived values.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
  logic       ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSource (PCSource),
    .ALUOp    (ALUOp),
    .State    (State),
    .Illegal  (Illegal)
  );

  always #5 clk = ~clk;

  // Every task starts and ends at a falling edge with the DUT in FETCH.
  task automatic test_reset();
    rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
    checks++;
    if ({PCWrite, MemRead, MemWrite, IRWrite, RegWrite} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got %b exp 00000",
                         {PCWrite, MemRead, MemWrite, IRWrite, RegWrite});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({MemRead, IRWrite, PCWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 2'd0}) begin
      errors++; $display("FAIL fetch_outputs got MR%b IR%b PW%b B%0d op%0d", MemRead, IRWrite,
                         PCWrite, ALUSrcB, ALUOp);
    end
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    Op = 6'h23;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (State !== 4'(exp_st[i])) begin
        errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, State, exp_st[i]);
      end
      checks++;
      if ({RegWrite, MemtoReg} !== {2{exp_st[i] == 4}}) begin
        errors++; $display("FAIL lw_wb[%0d] got %b exp %b", i, {RegWrite, MemtoReg},
                           {2{exp_st[i] == 4}});
      end
      if (exp_st[i] == 3) begin
        checks++;
        if ({MemRead, IorD} !== 2'b11) begin
          errors++; $display("FAIL lw_memrd got %b exp 11", {MemRead, IorD});
        end
      end
      if (exp_st[i] == 2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB} !== 3'b110) begin
          errors++; $display("FAIL lw_memadr got %b exp 110", {ALUSrcA, ALUSrcB});
        end
      end
    end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    Op = 6'h00; Funct = 6'h22;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (State !== 4'(exp_st[i])) begin
        errors++; $display("FAIL r_state[%0d] got %0d exp %0d", i, State, exp_st[i]);
      end
      if (exp_st[i] == 6 || exp_st[i] == 7) begin
        checks++;
        if (ALUOp !== 4'd2) begin errors++; $display("FAIL r_aluop got %0d exp 2", ALUOp); end
      end
      checks++;
      if ({RegWrite, RegDst} !== {2{exp_st[i] == 7}}) begin
        errors++; $display("FAIL r_wb[%0d] got %b exp %b", i, {RegWrite, RegDst},
                           {2{exp_st[i] == 7}});
      end
    end
    // NOR exercises a different Funct-to-ALUOp mapping.
    Funct = 6'h27;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({State, ALUOp} !== {4'd6, 4'd10}) begin
      errors++; $display("FAIL nor_exec got st%0d op%0d exp st6 op10", State, ALUOp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_branch();
    logic [5:0] ops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       zs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_pw[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      Op = ops[k]; Zero = zs[k];
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (State !== 4'd8) begin errors++; $display("FAIL br_state[%0d] got %0d exp 8", k, State); end
      checks++;
      if (PCWrite !== exp_pw[k]) begin
        errors++; $display("FAIL br_pcwrite[%0d] got %b exp %b", k, PCWrite, exp_pw[k]);
      end
      checks++;
      if ({PCSource, ALUOp, ALUSrcA} !== {2'd1, 4'd2, 1'b1}) begin
        errors++; $display("FAIL br_ctrl[%0d] got src%0d op%0d", k, PCSource, ALUOp);
      end
      @(negedge clk);
      #1;
      checks++;
      if (State !== 4'd0) begin errors++; $display("FAIL br_ret[%0d] got %0d exp 0", k, State); end
    end
    Zero = 1'b0;
  endtask

  task automatic test_itype();
    int exp_st[5] = '{0, 1, 9, 10, 0};
    Op = 6'h0C;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (State !== 4'(exp_st[i])) begin
        errors++; $display("FAIL i_state[%0d] got %0d exp %0d", i, State, exp_st[i]);
      end
      if (exp_st[i] == 9 || exp_st[i] == 10) begin
        checks++;
        if (ALUOp !== 4'd7) begin errors++; $display("FAIL i_aluop got %0d exp 7", ALUOp); end
      end
      checks++;
      if ({RegWrite, RegDst, MemtoReg} !== {exp_st[i] == 10, 2'b00}) begin
        errors++; $display("FAIL i_wb[%0d] got %b", i, {RegWrite, RegDst, MemtoReg});
      end
    end
  endtask

  task automatic test_jump();
    int exp_st[4] = '{0, 1, 11, 0};
    Op = 6'h02;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (State !== 4'(exp_st[i])) begin
        errors++; $display("FAIL j_state[%0d] got %0d exp %0d", i, State, exp_st[i]);
      end
      if (exp_st[i] == 11) begin
        checks++;
        if ({PCWrite, PCSource} !== 3'b110) begin
          errors++; $display("FAIL j_ctrl got %b exp 110", {PCWrite, PCSource});
        end
      end
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] funct);
    Op = op; Funct = funct;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({State, Illegal} !== {4'd12, 1'b1}) begin
        errors++; $display("FAIL trap[%0d] got st%0d ill%b exp st12 ill1", i, State, Illegal);
      end
      checks++;
      if ({PCWrite, MemRead, MemWrite, IRWrite, RegWrite} !== 5'b0) begin
        errors++; $display("FAIL trap_en[%0d] got %b exp 00000", i,
                           {PCWrite, MemRead, MemWrite, IRWrite, RegWrite});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({State, Illegal} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL trap_clr got st%0d ill%b exp st0 ill0", State, Illegal);
    end
    rst = 1'b0;
    Op = 6'h00; Funct = 6'h20;
  endtask

  task automatic test_reset_memwr();
    Op = 6'h2B;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({State, MemWrite} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL sw_memwr got st%0d mw%b exp st5 mw1", State, MemWrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwr got %b exp 0", MemWrite); end
    @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL rst_memwr_state got %0d exp 0", State); end
    rst = 1'b0;
    #1;
    checks++;
    if ({MemRead, IRWrite, PCWrite} !== 3'b111) begin
      errors++; $display("FAIL post_rst_fetch got %b exp 111", {MemRead, IRWrite, PCWrite});
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_itype();
    test_jump();
    test_illegal(6'h3F, 6'h20);
    test_illegal(6'h00, 6'h01);
    test_reset_memwr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the following ports, in the order given (name, direction, width, meaning):
  - clk, in, 1, single clock; all state updates on its rising edge.
  - rst, in, 1, synchronous active-high reset; sampled only on the rising edge of clk.
  - Op, in, 6, opcode field IR[31:26].
  - Funct, in, 6, function field IR[5:0].
  - Zero, in, 1, ALU equality flag (1 when srcA==srcB).
  - PCWrite, out, 1, PC load enable; includes the resolved branch condition.
  - IorD, out, 1, memory address select: 0=PC, 1=ALUOut.
  - MemRead, out, 1, memory read enable.
  - MemWrite, out, 1, memory write enable.
  - IRWrite, out, 1, instruction register load enable.
  - RegWrite, out, 1, register file write enable.
  - RegDst, out, 1, write register select: 0=rt, 1=rd.
  - MemtoReg, out, 1, write-back data select: 0=ALUOut, 1=MDR.
  - ALUSrcA, out, 1, ALU A select: 0=PC, 1=regA.
  - ALUSrcB, out, 2, ALU B select: 0=regB, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2.
  - PCSource, out, 2, next-PC select: 0=ALU result, 1=ALUOut, 2=jump target.
  - ALUOp, out, 4, ALU operation code driven to the ALU.
  - State, out, 4, current FSM state (debug).
  - Illegal, out, 1, high while trapped on an unsupported instruction.
REQ-002 ALUOp encodings SHALL be: ADD 0, ADDU 1, SUB 2, SUBU 3, SLLV 4, SRLV 5, SRAV 6, AND 7, OR 8, XOR 9, NOR 10, SLT 11, SLTU 12, SLL 13, SRL 14, SRA 15.

Function
REQ-003 The FSM SHALL use these state encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, TRAP 12.
REQ-004 Outputs SHALL be Moore-decoded from State; the only exception is PCWrite in BRANCH, which also depends on Zero.
REQ-005 Every output not listed for a state SHALL be 0.
REQ-006 FETCH SHALL assert MemRead, IRWrite and PCWrite, with IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0; next state DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ALUOp=ADD to precompute the branch target into ALUOut.
REQ-008 DECODE next state by Op: 0x23/0x2B go to MEMADR; 0x00 goes to REXEC if Funct is supported, else TRAP; 0x04/0x05 go to BRANCH; 0x08/0x09/0x0C/0x0D go to IEXEC; 0x02 goes to JUMP; any other Op goes to TRAP.
REQ-009 Supported Funct values SHALL be: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV.
REQ-010 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=ADD; next state MEMRD if Op=0x23, else MEMWR.
REQ-011 MEMRD SHALL assert MemRead with IorD=1; next state MEMWB.
REQ-012 MEMWB SHALL assert RegWrite with RegDst=0, MemtoReg=1; next state FETCH.
REQ-013 MEMWR SHALL assert MemWrite with IorD=1; next state FETCH.
REQ-014 REXEC SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp mapped from Funct per REQ-009; next state RWB.
REQ-015 RWB SHALL assert RegWrite with RegDst=1, MemtoReg=0, holding the REXEC ALUOp; next state FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1; PCWrite SHALL equal Zero for Op=0x04 and ~Zero for Op=0x05; next state FETCH.
REQ-017 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=2, with ALUOp ADD for 0x08, ADDU for 0x09, AND for 0x0C, OR for 0x0D; next state IWB.
REQ-018 IWB SHALL assert RegWrite with RegDst=0, MemtoReg=0, holding the IEXEC ALUOp; next state FETCH.
REQ-019 JUMP SHALL assert PCWrite with PCSource=2; next state FETCH.
REQ-020 TRAP SHALL assert Illegal, keep all enables at 0, and remain in TRAP until reset.
REQ-021 Instruction latency SHALL be, from FETCH to the next FETCH: lw 5 cycles; sw, R-type and I-type 4 cycles; beq, bne and j 3 cycles.
REQ-022 Op and Funct SHALL be assumed stable from the cycle after FETCH onward; the block SHALL NOT latch them.

Reset
REQ-023 When rst is sampled high, State SHALL become FETCH on that edge.
REQ-024 While rst is high, PCWrite, MemRead, MemWrite, IRWrite and RegWrite SHALL be forced to 0.
REQ-025 Asserting reset mid-instruction or in TRAP SHALL abort the instruction with no further write; Illegal SHALL clear.
REQ-026 After rst deasserts, the first cycle SHALL be FETCH with full FETCH outputs.

Verification
REQ-027 Reset then lw (Op=0x23): State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-028 R-type with Funct=0x22: State 0,1,6,7,0; ALUOp=2 in states 6 and 7; RegDst=1 in state 7.
REQ-029 beq with Zero=1, then beq with Zero=0: PCWrite=1 in BRANCH for the first and 0 for the second; bne inverts both results.
REQ-030 Op=0x3F: Illegal=1 from the cycle after DECODE; it holds for at least 10 cycles with all enables 0 and clears on reset.
REQ-031 Reset asserted in MEMWR: MemWrite=0 in that cycle; State=0 after the edge.
REQ-032 j (Op=0x02): State 0,1,11,0; PCWrite=1 and PCSource=2 in state 11.
